// File: rtl/ysyx_24090003_mem_arb_pkg.sv
// Shared types and constants for the SimpleBus memory arbiter.
// Arbiter FSM state type, default latency and index-width helper.
package ysyx_24090003_mem_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE   = 2'd0,
        ARB_ACCESS = 2'd1,
        ARB_WAIT   = 2'd2,
        ARB_RESP   = 2'd3
    } arb_state_e;

    localparam int unsigned MEM_LAT = 1;

    // Width of an index into n channels; a single channel still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/ysyx_24090003_mem_arb_if.sv
// Requester channels plus the single memory port of the arbiter.
// The slave modport is the arbiter's view; master is the requesters/memory side.
interface ysyx_24090003_mem_arb_if #(
    parameter int unsigned N_CH = 2,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32
);
    localparam int unsigned MW = DW / 8;

    logic [N_CH-1:0]    i_req_valid;
    logic [N_CH-1:0]    o_req_ready;
    logic [N_CH-1:0]    i_req_we;
    logic [N_CH*AW-1:0] i_req_addr;
    logic [N_CH*DW-1:0] i_req_wdata;
    logic [N_CH*MW-1:0] i_req_wmask;
    logic [N_CH-1:0]    o_rsp_valid;
    logic [DW-1:0]      o_rsp_rdata;

    logic               o_mem_en;
    logic               o_mem_we;
    logic [AW-1:0]      o_mem_addr;
    logic [DW-1:0]      o_mem_wdata;
    logic [MW-1:0]      o_mem_wmask;
    logic [DW-1:0]      i_mem_rdata;

    modport slave (
        input  i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_wmask, i_mem_rdata,
        output o_req_ready, o_rsp_valid, o_rsp_rdata,
        output o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
    );

    modport master (
        output i_req_valid, i_req_we, i_req_addr, i_req_wdata, i_req_wmask, i_mem_rdata,
        input  o_req_ready, o_rsp_valid, o_rsp_rdata,
        input  o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_wmask
    );

endinterface

// File: rtl/ysyx_24090003_rr_arbiter.sv
// Round-robin grant over N valid lines; owns the search pointer.
// The pointer moves just past the granted channel on each advance strobe.
module ysyx_24090003_rr_arbiter
    import ysyx_24090003_mem_arb_pkg::*;
#(
    parameter  int unsigned N  = 2,
    localparam int unsigned IW = idx_width(N)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [N-1:0]  valid,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] grant_idx
);

    logic [IW-1:0] ptr;

    always_comb begin
        logic        found;
        int unsigned c;
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        c         = 0;
        for (int unsigned k = 0; k < N; k++) begin
            c = 32'(ptr) + k;
            if (c >= N) c = c - N;
            if (!found && valid[c]) begin
                found     = 1'b1;
                grant[c]  = 1'b1;
                grant_idx = IW'(c);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

endmodule

// File: rtl/ysyx_24090003_mem_arb.sv
// N-channel SimpleBus memory arbiter: round-robin grant, one outstanding
// transaction, LAT-cycle access-to-response latency, reads and writes acked.
module ysyx_24090003_mem_arb
    import ysyx_24090003_mem_arb_pkg::*;
#(
    parameter int unsigned N_CH = 2,
    parameter int unsigned AW   = 32,
    parameter int unsigned DW   = 32,
    parameter int unsigned LAT  = MEM_LAT
) (
    input logic                    i_clk,
    input logic                    i_rst_n,
    ysyx_24090003_mem_arb_if.slave bus
);

    localparam int unsigned MW = DW / 8;
    localparam int unsigned IW = idx_width(N_CH);
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;

    arb_state_e      state;
    logic [N_CH-1:0] grant;
    logic [IW-1:0]   grant_idx;
    logic [N_CH-1:0] ready;
    logic            accept;
    logic [N_CH-1:0] owner;
    logic [CW-1:0]   cnt;

    logic            mem_en_q;
    logic            mem_we_q;
    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_wdata_q;
    logic [MW-1:0]   mem_wmask_q;
    logic [N_CH-1:0] rsp_valid_q;
    logic [DW-1:0]   rsp_rdata_q;

    ysyx_24090003_rr_arbiter #(.N(N_CH)) u_rr (
        .i_clk     (i_clk),
        .i_rst_n   (i_rst_n),
        .valid     (bus.i_req_valid),
        .advance   (accept),
        .grant     (grant),
        .grant_idx (grant_idx)
    );

    // Ready is held low while reset is asserted so nothing is accepted then.
    assign ready  = (i_rst_n && state == ARB_IDLE) ? grant : '0;
    assign accept = |(bus.i_req_valid & ready);

    assign bus.o_req_ready = ready;
    assign bus.o_rsp_valid = rsp_valid_q;
    assign bus.o_rsp_rdata = rsp_rdata_q;
    assign bus.o_mem_en    = mem_en_q;
    assign bus.o_mem_we    = mem_we_q;
    assign bus.o_mem_addr  = mem_addr_q;
    assign bus.o_mem_wdata = mem_wdata_q;
    assign bus.o_mem_wmask = mem_wmask_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state       <= ARB_IDLE;
            owner       <= '0;
            cnt         <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            rsp_valid_q <= '0;
            rsp_rdata_q <= '0;
        end else begin
            unique case (state)
                ARB_IDLE: begin
                    if (accept) begin
                        owner       <= grant;
                        mem_en_q    <= 1'b1;
                        mem_we_q    <= bus.i_req_we[grant_idx];
                        mem_addr_q  <= bus.i_req_addr[grant_idx*AW +: AW];
                        mem_wdata_q <= bus.i_req_wdata[grant_idx*DW +: DW];
                        mem_wmask_q <= bus.i_req_wmask[grant_idx*MW +: MW];
                        state       <= ARB_ACCESS;
                    end
                end
                ARB_ACCESS: begin
                    mem_en_q    <= 1'b0;
                    rsp_rdata_q <= mem_we_q ? '0 : bus.i_mem_rdata;
                    if (LAT > 1) begin
                        cnt   <= CW'(LAT - 1);
                        state <= ARB_WAIT;
                    end else begin
                        rsp_valid_q <= owner;
                        state       <= ARB_RESP;
                    end
                end
                ARB_WAIT: begin
                    if (cnt == CW'(1)) begin
                        rsp_valid_q <= owner;
                        state       <= ARB_RESP;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ARB_RESP: begin
                    rsp_valid_q <= '0;
                    state       <= ARB_IDLE;
                end
                default: state <= ARB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24090003_mem_arb.sv
// Bench for ysyx_24090003_mem_arb: a 2-channel LAT=1 and a 4-channel LAT=3
// instance, directed scenarios then random traffic against a transaction model.
module tb_ysyx_24090003_mem_arb;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned MW = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ysyx_24090003_mem_arb_if #(.N_CH(2), .AW(AW), .DW(DW)) busa ();
    ysyx_24090003_mem_arb_if #(.N_CH(4), .AW(AW), .DW(DW)) busb ();

    ysyx_24090003_mem_arb #(.N_CH(2), .AW(AW), .DW(DW), .LAT(1)) u_dut_a (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (busa)
    );

    ysyx_24090003_mem_arb #(.N_CH(4), .AW(AW), .DW(DW), .LAT(3)) u_dut_b (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (busb)
    );

    // sel picks which instance the shared stimulus and views refer to.
    logic            sel;
    logic [3:0]      va;
    logic [3:0]      vwe;
    logic [4*AW-1:0] vaddr;
    logic [4*DW-1:0] vwdata;
    logic [4*MW-1:0] vwmask;

    function automatic logic [DW-1:0] mem_f(input logic [AW-1:0] a);
        if (a == 32'h8000_0000) return 32'h0000_0413;
        return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
    endfunction

    assign busa.i_req_valid = sel ? 2'b00 : va[1:0];
    assign busa.i_req_we    = vwe[1:0];
    assign busa.i_req_addr  = vaddr[2*AW-1:0];
    assign busa.i_req_wdata = vwdata[2*DW-1:0];
    assign busa.i_req_wmask = vwmask[2*MW-1:0];
    assign busa.i_mem_rdata = busa.o_mem_en ? mem_f(busa.o_mem_addr) : 32'hBAD0_BAD0;

    assign busb.i_req_valid = sel ? va : 4'b0000;
    assign busb.i_req_we    = vwe;
    assign busb.i_req_addr  = vaddr;
    assign busb.i_req_wdata = vwdata;
    assign busb.i_req_wmask = vwmask;
    assign busb.i_mem_rdata = busb.o_mem_en ? mem_f(busb.o_mem_addr) : 32'hBAD0_BAD0;

    logic [3:0]    ready_v, rsp_v;
    logic          en_v, mwe_v;
    logic [AW-1:0] maddr_v;
    logic [DW-1:0] mwdata_v, rdata_v;
    logic [MW-1:0] mwmask_v;

    always_comb begin
        if (sel) begin
            ready_v  = busb.o_req_ready;
            rsp_v    = busb.o_rsp_valid;
            rdata_v  = busb.o_rsp_rdata;
            en_v     = busb.o_mem_en;
            mwe_v    = busb.o_mem_we;
            maddr_v  = busb.o_mem_addr;
            mwdata_v = busb.o_mem_wdata;
            mwmask_v = busb.o_mem_wmask;
        end else begin
            ready_v  = {2'b00, busa.o_req_ready};
            rsp_v    = {2'b00, busa.o_rsp_valid};
            rdata_v  = busa.o_rsp_rdata;
            en_v     = busa.o_mem_en;
            mwe_v    = busa.o_mem_we;
            maddr_v  = busa.o_mem_addr;
            mwdata_v = busa.o_mem_wdata;
            mwmask_v = busa.o_mem_wmask;
        end
    end

    int unsigned   ptr_m [2];
    logic [DW-1:0] last_rd [2];
    int            checks = 0;
    int            errors = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_vals(input string tag);
        check({tag, "_ready"}, ready_v, 0);
        check({tag, "_rsp"}, rsp_v, 0);
        check({tag, "_rdata"}, rdata_v, 0);
        check({tag, "_en"}, en_v, 0);
        check({tag, "_we"}, mwe_v, 0);
        check({tag, "_addr"}, maddr_v, 0);
        check({tag, "_wdata"}, mwdata_v, 0);
        check({tag, "_wmask"}, mwmask_v, 0);
    endtask

    task automatic rand_payload(input int unsigned c);
        vwe[c]              = 1'($urandom);
        vaddr[c*AW +: AW]   = $urandom;
        vwdata[c*DW +: DW]  = $urandom;
        vwmask[c*MW +: MW]  = 4'($urandom);
    endtask

    // One idle cycle with the given valids; if something is granted, follow
    // the transaction to its response. Entered and left just after a posedge.
    task automatic xact(input logic [3:0] valid, input logic [3:0] drop, input logic [3:0] extra);
        int unsigned   n, l, p, g;
        logic [3:0]    g_oh;
        logic [DW-1:0] exp_rd;
        logic [AW-1:0] exp_addr;
        n = sel ? 4 : 2;
        l = sel ? 3 : 1;
        p = ptr_m[sel];
        va = valid;
        g = 0;
        g_oh = '0;
        for (int unsigned k = 0; k < n; k++) begin
            int unsigned c;
            c = (p + k) % n;
            if (g_oh == '0 && valid[c]) begin
                g = c;
                g_oh[c] = 1'b1;
            end
        end
        @(negedge clk);
        check("idle_ready", ready_v, g_oh);
        check("idle_en", en_v, 0);
        check("idle_rsp", rsp_v, 0);
        check("rdata_hold", rdata_v, last_rd[sel]);
        step();
        if (g_oh == '0) return;

        ptr_m[sel] = (g + 1) % n;
        exp_addr = vaddr[g*AW +: AW];
        exp_rd = vwe[g] ? '0 : mem_f(exp_addr);
        va = (valid & ~g_oh & ~drop) | extra;
        @(negedge clk);
        check("acc_en", en_v, 1);
        check("acc_we", mwe_v, vwe[g]);
        check("acc_addr", maddr_v, exp_addr);
        check("acc_wdata", mwdata_v, vwdata[g*DW +: DW]);
        check("acc_wmask", mwmask_v, vwmask[g*MW +: MW]);
        check("busy_ready", ready_v, 0);
        step();
        for (int unsigned i = 0; i + 1 < l; i++) begin
            @(negedge clk);
            check("wait_en", en_v, 0);
            check("wait_rsp", rsp_v, 0);
            check("wait_addr", maddr_v, exp_addr);
            check("busy_ready", ready_v, 0);
            step();
        end
        @(negedge clk);
        check("rsp_valid", rsp_v, g_oh);
        check("rsp_rdata", rdata_v, exp_rd);
        check("rsp_en", en_v, 0);
        check("busy_ready", ready_v, 0);
        last_rd[sel] = exp_rd;
        step();
    endtask

    task automatic rand_phase(input int iters);
        for (int it = 0; it < iters; it++) begin
            logic [3:0] nv;
            nv = (va & 4'($urandom)) | 4'($urandom);
            if (!sel) nv[3:2] = 2'b00;
            for (int unsigned c = 0; c < 4; c++) begin
                if (!va[c]) rand_payload(c);
            end
            xact(nv, 4'($urandom), 4'b0000);
        end
    endtask

    initial begin
        sel = 1'b0;
        va = 4'b1111;
        vwe = '0;
        vaddr = '0;
        vwdata = '0;
        vwmask = '0;
        ptr_m[0] = 0;
        ptr_m[1] = 0;
        last_rd[0] = '0;
        last_rd[1] = '0;

        repeat (2) step();
        @(negedge clk);
        sel = 1'b0; #1;
        reset_vals("rst_a");
        sel = 1'b1; #1;
        reset_vals("rst_b");
        sel = 1'b0;
        va = '0;
        rst_n = 1'b1;
        step();

        // 2 channels, LAT=1: read of 0x80000000 returning 0x00000413.
        vwe[0] = 1'b0;
        vaddr[0 +: AW] = 32'h8000_0000;
        xact(4'b0001, 4'b0000, 4'b0000);

        // ch0 raises valid while busy, then drops it before the next grant.
        rand_payload(1);
        vwe[1] = 1'b0;
        xact(4'b0010, 4'b0000, 4'b0001);
        xact(4'b0010, 4'b0000, 4'b0000);

        // Both channels continuously valid: grants alternate.
        repeat (4) xact(4'b0011, 4'b0000, 4'b0000);
        xact(4'b0011, 4'b0011, 4'b0000);

        rand_phase(50);

        va = '0;
        sel = 1'b1;
        step();

        // 4 channels, LAT=3: masked write on ch1.
        vwe[1] = 1'b1;
        vaddr[1*AW +: AW] = 32'h8000_1000;
        vwdata[1*DW +: DW] = 32'hDEAD_BEEF;
        vwmask[1*MW +: MW] = 4'b0011;
        xact(4'b0010, 4'b0000, 4'b0000);

        // ptr now 2 with channels 1 and 3 valid: 3 first, then 1.
        rand_payload(3);
        vwe[1] = 1'b0;
        xact(4'b1010, 4'b0000, 4'b0000);
        xact(va, 4'b0000, 4'b0000);

        // Zero-mask write still strobes memory.
        vwe[0] = 1'b1;
        vwmask[0 +: MW] = 4'b0000;
        xact(4'b0001, 4'b0000, 4'b0000);

        // Reset asserted in the WAIT phase of a ch2 read.
        vwe[2] = 1'b0;
        vaddr[2*AW +: AW] = 32'h8000_2000;
        va = 4'b0100;
        @(negedge clk);
        check("rstw_ready", ready_v, 4'b0100);
        step();
        @(negedge clk);
        check("rstw_en", en_v, 1);
        step();
        @(negedge clk);
        check("rstw_wait_en", en_v, 0);
        rst_n = 1'b0;
        step();
        @(negedge clk);
        reset_vals("rst_mid");
        va = '0;
        rst_n = 1'b1;
        ptr_m[0] = 0;
        ptr_m[1] = 0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        step();
        @(negedge clk);
        check("rst_no_rsp", rsp_v, 0);
        check("rst_no_en", en_v, 0);
        step();
        xact(4'b0100, 4'b0000, 4'b0000);

        rand_phase(60);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
